// File: rtl/shift_pkg.sv
// Shared defaults and output-stage state encoding for the shifter request queue.
package shift_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned SHIFT_LEN_DEF  = 3;

  typedef enum logic {
    O_EMPTY = 1'b0,
    O_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/shift_req_fifo.sv
// Request FIFO: DEPTH entries of {data, shift amount}, pointers and occupancy level.
module shift_req_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SHIFT_LEN  = 3,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [SHIFT_LEN-1:0]     i_bits,
  input  logic                     i_pop,
  output logic                     o_ready,
  output logic [DATA_WIDTH-1:0]    o_head_data,
  output logic [SHIFT_LEN-1:0]     o_head_bits,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + SHIFT_LEN;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_empty;
  logic [EW-1:0] w_head;

  // Full/empty come only from the registered level, never from the pointers.
  assign o_ready = (r_level < DepthL);
  assign w_empty = (r_level == '0);
  assign w_push  = i_push & o_ready;
  assign o_level = r_level;
  assign w_head  = r_mem[r_rd_ptr];

  // Head drives the shifter; zeros when empty so the shifter output is 0.
  always_comb begin
    o_head_data = '0;
    o_head_bits = '0;
    if (!w_empty) begin
      o_head_data = w_head[EW-1:SHIFT_LEN];
      o_head_bits = w_head[SHIFT_LEN-1:0];
    end
  end

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_data, i_bits};
  end

  // Pointer and level update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rshift_req_queue.sv
// Request queue ahead of the combinational right shifter, with a registered output stage.
module rshift_req_queue
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned SHIFT_LEN  = SHIFT_LEN_DEF,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_LEN-1:0]   in_bits,
  output logic [DATA_WIDTH-1:0]  shf_data,
  output logic [SHIFT_LEN-1:0]   shf_bits,
  input  logic [DATA_WIDTH-1:0]  shf_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [$clog2(DEPTH):0] level
);

  out_state_e            r_state;
  out_state_e            w_state_d;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_not_empty;

  shift_req_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_LEN  (SHIFT_LEN),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (in_valid),
    .i_data      (in_data),
    .i_bits      (in_bits),
    .i_pop       (w_pop),
    .o_ready     (in_ready),
    .o_head_data (shf_data),
    .o_head_bits (shf_bits),
    .o_level     (level)
  );

  assign w_not_empty = (level != '0);
  assign out_valid   = (r_state == O_FULL);
  assign out_data    = r_out_data;

  // Next-state and pop decision; a pop always coincides with a capture.
  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    unique case (r_state)
      O_EMPTY: begin
        if (w_not_empty) begin
          w_pop     = 1'b1;
          w_state_d = O_FULL;
        end
      end
      O_FULL: begin
        if (out_ready) begin
          if (w_not_empty) w_pop = 1'b1;
          else             w_state_d = O_EMPTY;
        end
      end
      default: w_state_d = O_EMPTY;
    endcase
  end

  // Output stage state and result register; data changes only on a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= O_EMPTY;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_pop) r_out_data <= shf_result;
    end
  end

endmodule

// File: tb/tb_rshift_req_queue.sv
// Self-checking bench for rshift_req_queue with a queue-based reference model.
module tb_rshift_req_queue;
  import shift_pkg::*;

  localparam int unsigned DW    = DATA_WIDTH_DEF;
  localparam int unsigned SL    = SHIFT_LEN_DEF;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [SL-1:0] b;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [SL-1:0] in_bits = '0;
  logic [DW-1:0] shf_data;
  logic [SL-1:0] shf_bits;
  logic [DW-1:0] shf_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in for the rshifter instance.
  assign shf_result = shf_data >> shf_bits;

  rshift_req_queue #(
    .DATA_WIDTH (DW),
    .SHIFT_LEN  (SL),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_bits    (in_bits),
    .shf_data   (shf_data),
    .shf_bits   (shf_bits),
    .shf_result (shf_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted requests in a queue, one result slot downstream.
  req_t          m_q[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      int   n;
      bit   acc;
      bit   take;
      req_t r;
      n    = m_q.size();
      acc  = in_valid && (n < DEPTH);
      take = (n > 0) && (!m_valid || out_ready);
      if (take) begin
        m_data  = m_q[0].d >> m_q[0].b;
        m_valid = 1'b1;
        void'(m_q.pop_front());
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        r.d = in_data;
        r.b = in_bits;
        m_q.push_back(r);
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    chk("m_level", 32'(level), 32'(m_q.size()));
    chk("m_in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    chk("m_out_data", 32'(out_data), 32'(m_data));
    chk("m_shf_data", 32'(shf_data), (m_q.size() > 0) ? 32'(m_q[0].d) : 32'd0);
    chk("m_shf_bits", 32'(shf_bits), (m_q.size() > 0) ? 32'(m_q[0].b) : 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sweep_exp [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
  logic [DW-1:0] full_d    [6] = '{8'hA5, 8'h3C, 8'hF0, 8'h99, 8'h7E, 8'h55};
  logic [SL-1:0] full_b    [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
  logic [DW-1:0] full_exp  [5] = '{8'h52, 8'h0F, 8'h1E, 8'h09, 8'h7E};

  initial begin
    // Power-on reset.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single request: B4 >> 3 = 16, one edge after acceptance.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB4;
    in_bits   = 3'd3;
    step();
    in_valid = 1'b0;
    chk("single_level1", 32'(level), 32'd1);
    chk("single_no_valid", 32'(out_valid), 32'd0);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h16);
    chk("single_level0", 32'(level), 32'd0);
    step();
    chk("single_drained", 32'(out_valid), 32'd0);

    // Sweep of shift amounts, one result per cycle.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_bits = SL'(i);
      step();
      if (i > 0) begin
        chk("sweep_valid", 32'(out_valid), 32'd1);
        chk("sweep_data", 32'(out_data), 32'(sweep_exp[i-1]));
      end
    end
    in_valid = 1'b0;
    step();
    chk("sweep_last", 32'(out_data), 32'(sweep_exp[7]));
    step();
    chk("sweep_drained", 32'(out_valid), 32'd0);

    // Fill under backpressure; sixth request is dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = full_d[i];
      in_bits = full_b[i];
      step();
    end
    in_valid = 1'b0;
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);

    // Hold: result stays put while out_ready is low.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", 32'(out_data), 32'(full_exp[0]));
      chk("hold_valid", 32'(out_valid), 32'd1);
    end

    // Release: five results in order, then empty.
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("release_data", 32'(out_data), 32'(full_exp[i]));
    end
    step();
    chk("release_done", 32'(out_valid), 32'd0);
    chk("release_level", 32'(level), 32'd0);

    // Build level 2, then push and pop together for 10 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h21 + DW'(i);
      in_bits = SL'(i);
      step();
    end
    chk("pp_start_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(8'h11 * (i + 1));
      in_bits = SL'(i % 8);
      step();
      chk("pp_level", 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("pp_drained", 32'(out_valid), 32'd0);

    // Reset mid-stream with level 3 and a held result.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hC3 ^ DW'(i);
      in_bits = SL'(i + 1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
